// File: rtl/elevator_status_display.sv
// elevator_status_display: samples car status, builds a four-glyph message
// and time-multiplexes it onto an active-low seven-segment display.
module elevator_status_display #(
  parameter int NUM_FLOORS = 5,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 200000,
  parameter int BLINK_DIV  = 25000000,
  parameter int SEC_DIV    = 100000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] floor,
  input  logic                  up,
  input  logic                  down,
  input  logic                  stop,
  input  logic                  door_closed,
  output logic [NUM_DIGITS-1:0] ssSel,
  output logic [0:7]            ssDisp,
  output logic                  sec_tick,
  output logic                  status_err
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int TW = $clog2(SEC_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [7:0] G_O     = 8'b00000011;
  localparam logic [7:0] G_P     = 8'b00110001;
  localparam logic [7:0] G_C     = 8'b01100011;
  localparam logic [7:0] G_L     = 8'b11100011;
  localparam logic [7:0] G_U     = 8'b10000011;
  localparam logic [7:0] G_D     = 8'b10000101;
  localparam logic [7:0] G_E     = 8'b01100001;
  localparam logic [7:0] G_DASH  = 8'b11111101;
  localparam logic [7:0] G_BLANK = 8'b11111111;

  typedef struct packed {
    logic                  vld;
    logic [NUM_FLOORS-1:0] flr;
    logic                  up;
    logic                  down;
    logic                  stop;
    logic                  door;
  } stat_t;

  function automatic logic [7:0] num_glyph(input logic [3:0] n);
    case (n)
      4'd0:    num_glyph = 8'b00000011;
      4'd1:    num_glyph = 8'b10011111;
      4'd2:    num_glyph = 8'b00100101;
      4'd3:    num_glyph = 8'b00001101;
      4'd4:    num_glyph = 8'b10011001;
      4'd5:    num_glyph = 8'b01001001;
      4'd6:    num_glyph = 8'b01000001;
      4'd7:    num_glyph = 8'b00011111;
      4'd8:    num_glyph = 8'b00000001;
      4'd9:    num_glyph = 8'b00001001;
      default: num_glyph = G_BLANK;
    endcase
  endfunction

  stat_t           stat_q, stat_d;
  logic [7:0]      buf_q [NUM_DIGITS];
  logic [7:0]      buf_d [NUM_DIGITS];
  logic            err_q, err_d;
  logic            dblink_q, dblink_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [TW-1:0]   sec_cnt_q, sec_cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            phase_q, phase_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]      disp_q, disp_d;
  logic            tick_q, tick_d;

  logic [3:0]      fl_cnt, fl_num;
  logic            fl_ok, dir_ok;
  logic            mv_up, mv_dn, mv_st;
  logic [7:0]      dir_g;
  logic            scan_wrap, blink_wrap, sec_wrap;
  logic            blank_hi, blank_lo;

  always_comb begin
    stat_d.vld  = 1'b1;
    stat_d.flr  = floor;
    stat_d.up   = up;
    stat_d.down = down;
    stat_d.stop = stop;
    stat_d.door = door_closed;
  end

  always_comb begin
    fl_cnt = 4'd0;
    fl_num = 4'd0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (stat_q.flr[i]) begin
        fl_cnt = fl_cnt + 4'd1;
        fl_num = 4'(i + 1);
      end
    end
    fl_ok = (fl_cnt == 4'd1);
  end

  always_comb begin
    mv_up  = stat_q.up & ~stat_q.down & ~stat_q.stop;
    mv_dn  = ~stat_q.up & stat_q.down & ~stat_q.stop;
    mv_st  = ~stat_q.up & ~stat_q.down & stat_q.stop;
    dir_ok = mv_up | mv_dn | mv_st;
    unique case (1'b1)
      mv_up:   dir_g = G_U;
      mv_dn:   dir_g = G_D;
      mv_st:   dir_g = G_DASH;
      default: dir_g = G_E;
    endcase
  end

  // Buffers stay blank until the status register holds a real sample.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) buf_d[i] = buf_q[i];
    err_d    = err_q;
    dblink_d = dblink_q;
    if (stat_q.vld) begin
      for (int i = 0; i < NUM_DIGITS; i++) buf_d[i] = G_BLANK;
      buf_d[3] = stat_q.door ? G_C : G_O;
      buf_d[2] = stat_q.door ? G_L : G_P;
      buf_d[1] = dir_g;
      buf_d[0] = fl_ok ? num_glyph(fl_num) : G_E;
      err_d    = ~dir_ok | ~fl_ok;
      dblink_d = ~stat_q.door & (stat_q.up | stat_q.down);
    end
  end

  always_comb begin
    scan_wrap   = (scan_cnt_q == SW'(SCAN_DIV - 1));
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SW'(1);
    idx_d       = idx_q;
    if (scan_wrap)
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    blink_wrap  = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    phase_d     = phase_q ^ blink_wrap;
    sec_wrap    = (sec_cnt_q == TW'(SEC_DIV - 1));
    sec_cnt_d   = sec_wrap ? '0 : sec_cnt_q + TW'(1);
    tick_d      = sec_wrap;
  end

  // Select and data are both derived from the next index, so they move together.
  always_comb begin
    sel_d  = ~(NUM_DIGITS'(1) << idx_d);
    disp_d = G_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_d == IW'(i)) disp_d = buf_d[i];
    blank_hi = phase_d & dblink_d &
               ((idx_d == IW'(2)) | (idx_d == IW'(3)));
    blank_lo = phase_d & err_d &
               ((idx_d == IW'(0)) | (idx_d == IW'(1)));
    if (blank_hi | blank_lo) disp_d = G_BLANK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q      <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= G_BLANK;
      err_q       <= 1'b0;
      dblink_q    <= 1'b0;
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      sec_cnt_q   <= '0;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      sel_q       <= ~NUM_DIGITS'(1);
      disp_q      <= G_BLANK;
      tick_q      <= 1'b0;
    end else begin
      stat_q      <= stat_d;
      for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= buf_d[i];
      err_q       <= err_d;
      dblink_q    <= dblink_d;
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      sel_q       <= sel_d;
      disp_q      <= disp_d;
      tick_q      <= tick_d;
    end
  end

  assign ssSel      = sel_q;
  assign ssDisp     = disp_q;
  assign sec_tick   = tick_q;
  assign status_err = err_q;

endmodule
